// File: rtl/accel_sample_scheduler.sv
// Configures the ADXL345 over SPI, then issues periodic 6-byte read bursts and streams them to a UART.
// Optional macro ACCEL_SYNC_BYTE_EN frames each packet with a 0xA5 sync byte and an XOR checksum.
module accel_sample_scheduler #(
  parameter int CLK_FREQ       = 5_000_000,
  parameter int SAMPLE_RATE    = 100,
  parameter int STARTUP_CYCLES = 5_000,
  parameter int SPI_TIMEOUT    = 4_096
) (
  input  logic        clk,
  input  logic        rst,
  output logic [56:0] spi_frame,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [47:0] spi_rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cfg_done,
  output logic        err,
  output logic [7:0]  overrun_cnt
);

  localparam int SAMPLE_DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int SW = $clog2(SAMPLE_DIV + 1);
  localparam int BW = $clog2(STARTUP_CYCLES + 1);
  localparam int WW = $clog2(SPI_TIMEOUT + 1);
`ifdef ACCEL_SYNC_BYTE_EN
  localparam int PKT_LEN = 8;
`else
  localparam int PKT_LEN = 6;
`endif

  localparam logic [56:0] FMT_FRAME = {1'b0, 1'b0, 6'h31, 8'h40, 1'b1, 40'h0};
  localparam logic [56:0] PWR_FRAME = {1'b0, 1'b0, 6'h2D, 8'h08, 1'b1, 40'h0};
  localparam logic [56:0] RD_FRAME  = {1'b1, 1'b1, 6'h32, 48'h0, 1'b1};

  typedef enum logic [3:0] {
    S_BOOT, S_FMT, S_FMT_W, S_PWR, S_PWR_W, S_IDLE, S_RD, S_RD_W, S_TX
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] boot_cnt, boot_nxt;
  logic [WW-1:0] wd_cnt, wd_nxt;
  logic [SW-1:0] samp_cnt, samp_nxt;
  logic          tick, tick_nxt;
  logic [2:0]    byte_idx, idx_nxt;
  logic [47:0]   cap;
  logic          cap_ld, timeout;
  logic [56:0]   frame_nxt;
  logic          start_nxt, txv_nxt, cfg_nxt, err_nxt;
  logic [7:0]    txd_nxt, ovr_nxt;

  // Packet byte at position idx, drawn from the captured burst d
  function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [47:0] d);
    logic [7:0] b;
    b = 8'h00;
`ifdef ACCEL_SYNC_BYTE_EN
    case (idx)
      3'd0:    b = 8'hA5;
      3'd1:    b = d[47:40];
      3'd2:    b = d[39:32];
      3'd3:    b = d[31:24];
      3'd4:    b = d[23:16];
      3'd5:    b = d[15:8];
      3'd6:    b = d[7:0];
      default: b = d[47:40] ^ d[39:32] ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endcase
`else
    case (idx)
      3'd0:    b = d[47:40];
      3'd1:    b = d[39:32];
      3'd2:    b = d[31:24];
      3'd3:    b = d[23:16];
      3'd4:    b = d[15:8];
      3'd5:    b = d[7:0];
      default: b = 8'h00;
    endcase
`endif
    return b;
  endfunction

  always_comb begin
    state_nxt = state;
    boot_nxt  = boot_cnt;
    wd_nxt    = '0;
    samp_nxt  = samp_cnt;
    tick_nxt  = 1'b0;
    idx_nxt   = byte_idx;
    cap_ld    = 1'b0;
    timeout   = 1'b0;
    start_nxt = 1'b0;
    frame_nxt = spi_frame;
    txv_nxt   = tx_valid;
    txd_nxt   = tx_data;
    cfg_nxt   = cfg_done;
    err_nxt   = err;
    ovr_nxt   = overrun_cnt;

    // spi_done in the final watchdog cycle still counts as success
    if (state == S_FMT_W || state == S_PWR_W || state == S_RD_W) begin
      wd_nxt  = wd_cnt + WW'(1);
      timeout = !spi_done && (wd_cnt == WW'(SPI_TIMEOUT - 1));
    end

    if (cfg_done) begin
      if (samp_cnt == SW'(SAMPLE_DIV - 1)) begin
        samp_nxt = '0;
        tick_nxt = 1'b1;
      end else begin
        samp_nxt = samp_cnt + SW'(1);
      end
    end

    if (tick && state != S_IDLE && overrun_cnt != 8'hFF)
      ovr_nxt = overrun_cnt + 8'd1;

    case (state)
      S_BOOT: begin
        if (boot_cnt == BW'(STARTUP_CYCLES - 1)) begin
          boot_nxt  = '0;
          state_nxt = S_FMT;
        end else begin
          boot_nxt = boot_cnt + BW'(1);
        end
      end
      S_FMT: if (!spi_busy) begin
        start_nxt = 1'b1;
        frame_nxt = FMT_FRAME;
        state_nxt = S_FMT_W;
      end
      S_FMT_W: if (spi_done) state_nxt = S_PWR;
      S_PWR: if (!spi_busy) begin
        start_nxt = 1'b1;
        frame_nxt = PWR_FRAME;
        state_nxt = S_PWR_W;
      end
      S_PWR_W: if (spi_done) begin
        cfg_nxt   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_IDLE: if (tick) state_nxt = S_RD;
      S_RD: if (!spi_busy) begin
        start_nxt = 1'b1;
        frame_nxt = RD_FRAME;
        state_nxt = S_RD_W;
      end
      S_RD_W: if (spi_done) begin
        cap_ld    = 1'b1;
        txv_nxt   = 1'b1;
        txd_nxt   = pkt_byte(3'd0, spi_rx_data);
        idx_nxt   = 3'd0;
        state_nxt = S_TX;
      end
      S_TX: if (tx_valid && tx_ready) begin
        if (byte_idx == 3'(PKT_LEN - 1)) begin
          txv_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          idx_nxt = byte_idx + 3'd1;
          txd_nxt = pkt_byte(byte_idx + 3'd1, cap);
        end
      end
      default: state_nxt = S_BOOT;
    endcase

    // A hung engine forces a full reconfiguration from FORMAT
    if (timeout) begin
      err_nxt   = 1'b1;
      cfg_nxt   = 1'b0;
      samp_nxt  = '0;
      tick_nxt  = 1'b0;
      state_nxt = S_FMT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      boot_cnt    <= '0;
      wd_cnt      <= '0;
      samp_cnt    <= '0;
      tick        <= 1'b0;
      byte_idx    <= '0;
      spi_start   <= 1'b0;
      spi_frame   <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      cfg_done    <= 1'b0;
      err         <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state       <= state_nxt;
      boot_cnt    <= boot_nxt;
      wd_cnt      <= wd_nxt;
      samp_cnt    <= samp_nxt;
      tick        <= tick_nxt;
      byte_idx    <= idx_nxt;
      spi_start   <= start_nxt;
      spi_frame   <= frame_nxt;
      tx_valid    <= txv_nxt;
      tx_data     <= txd_nxt;
      cfg_done    <= cfg_nxt;
      err         <= err_nxt;
      overrun_cnt <= ovr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_ld) cap <= spi_rx_data;
  end

endmodule

// File: tb/tb_accel_sample_scheduler.sv
// Directed bench for accel_sample_scheduler with a behavioural SPI engine answering each frame.
module tb_accel_sample_scheduler;

  localparam int CLK_FREQ    = 2000;
  localparam int SAMPLE_RATE = 10;
  localparam int SD          = 200;
  localparam int STARTUP     = 20;
  localparam int TO          = 64;
  localparam int ENG_LAT     = 60;

  localparam logic [56:0] FMT_F = {1'b0, 1'b0, 6'h31, 8'h40, 1'b1, 40'h0};
  localparam logic [56:0] PWR_F = {1'b0, 1'b0, 6'h2D, 8'h08, 1'b1, 40'h0};
  localparam logic [56:0] RD_F  = {1'b1, 1'b1, 6'h32, 48'h0, 1'b1};
`ifdef ACCEL_SYNC_BYTE_EN
  localparam int PKT  = 8;
  localparam int I_03 = 3;
`else
  localparam int PKT  = 6;
  localparam int I_03 = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [56:0] spi_frame;
  logic        spi_start;
  logic        spi_busy;
  logic        spi_done;
  logic [47:0] spi_rx_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        cfg_done;
  logic        err;
  logic [7:0]  overrun_cnt;

  logic        resp_reads = 1'b1;
  logic [47:0] rx_pattern = 48'h0102_0304_0506;
  int          cyc = 0;
  int          done_edge = -1;
  logic [56:0] flog[$];
  logic [7:0]  exp_pkt[0:7];
  int          vecs = 0;
  int          errs = 0;

  accel_sample_scheduler #(
    .CLK_FREQ(CLK_FREQ), .SAMPLE_RATE(SAMPLE_RATE),
    .STARTUP_CYCLES(STARTUP), .SPI_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .spi_frame(spi_frame), .spi_start(spi_start),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx_data(spi_rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_done(cfg_done), .err(err), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SPI engine: answers writes always, reads only while resp_reads is set
  initial begin
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx_data = '0;
    forever begin
      step();
      if (spi_start === 1'b1) begin
        flog.push_back(spi_frame);
        if (!spi_frame[56] || resp_reads) begin
          spi_busy = 1'b1;
          repeat (ENG_LAT - 1) step();
          spi_rx_data = rx_pattern;
          spi_done = 1'b1;
          done_edge = cyc + 1;
          step();
          spi_done = 1'b0;
          spi_busy = 1'b0;
          spi_rx_data = '0;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tx_ready = 1'b0;
    repeat (3) step();
    vecs++;
    if ({spi_start, tx_valid, cfg_done, err} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_flags got start/txv/cfg/err=%b want 0000", {spi_start, tx_valid, cfg_done, err});
    end
    vecs++;
    if (spi_frame !== 57'h0) begin
      errs++;
      $display("FAIL reset_frame got %h want 0", spi_frame);
    end
    vecs++;
    if (tx_data !== 8'h00 || overrun_cnt !== 8'h00) begin
      errs++;
      $display("FAIL reset_data got tx_data=%h ovr=%h want 00/00", tx_data, overrun_cnt);
    end
  endtask

  task automatic test_boot_config();
    int n;
    int k;
    flog.delete();
    rst = 1'b0;
    n = 0;
    do begin step(); n++; end while (spi_start !== 1'b1 && n < 200);
    vecs++;
    if (n !== STARTUP + 1) begin
      errs++;
      $display("FAIL boot_first_start got %0d cycles want %0d", n, STARTUP + 1);
    end
    n = 0;
    while (cfg_done !== 1'b1 && n < 400) begin step(); n++; end
    vecs++;
    if (cfg_done !== 1'b1 || flog.size() != 2) begin
      errs++;
      $display("FAIL cfg_done got cfg=%b frames=%0d want 1/2", cfg_done, flog.size());
    end else begin
      vecs++;
      if (flog[0] !== FMT_F || flog[1] !== PWR_F) begin
        errs++;
        $display("FAIL cfg_frames got %h %h want %h %h", flog[0], flog[1], FMT_F, PWR_F);
      end
    end
    k = 0;
    do begin step(); k++; end while (spi_start !== 1'b1 && k < SD + 20);
    vecs++;
    if (k < SD || k > SD + 3 || spi_frame !== RD_F) begin
      errs++;
      $display("FAIL first_read got k=%0d frame=%h want k in [%0d,%0d] frame=%h", k, spi_frame, SD, SD + 3, RD_F);
    end
  endtask

  task automatic test_sample_stream();
    int n;
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid !== 1'b1 && n < 2 * SD) begin step(); n++; end
    vecs++;
    if (cyc != done_edge) begin
      errs++;
      $display("FAIL stream_latency got edge %0d want %0d", cyc, done_edge);
    end
    for (int i = 0; i < PKT; i++) begin
      vecs++;
      if (tx_valid !== 1'b1 || tx_data !== exp_pkt[i]) begin
        errs++;
        $display("FAIL stream_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_pkt[i]);
      end
      step();
    end
    vecs++;
    if (tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL stream_end got tx_valid=%b want 0", tx_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    tx_ready = 1'b1;
    n = 0;
    while (!(tx_valid === 1'b1 && tx_data === 8'h03) && n < 2 * SD) begin step(); n++; end
    tx_ready = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (tx_valid !== 1'b1 || tx_data !== 8'h03) bad++;
    end
    vecs++;
    if (bad != 0 || n >= 2 * SD) begin
      errs++;
      $display("FAIL bp_hold got %0d unstable cycles (wait %0d) want 0", bad, n);
    end
    tx_ready = 1'b1;
    for (int i = I_03; i < PKT; i++) begin
      vecs++;
      if (tx_valid !== 1'b1 || tx_data !== exp_pkt[i]) begin
        errs++;
        $display("FAIL bp_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_pkt[i]);
      end
      step();
    end
    vecs++;
    if (tx_valid !== 1'b0 || overrun_cnt !== 8'd0) begin
      errs++;
      $display("FAIL bp_end got v=%b ovr=%0d want 0/0", tx_valid, overrun_cnt);
    end
  endtask

  task automatic test_overrun();
    int n;
    tx_ready = 1'b0;
    n = 0;
    while (tx_valid !== 1'b1 && n < 2 * SD) begin step(); n++; end
    repeat (3 * SD) step();
    vecs++;
    if (overrun_cnt !== 8'd3) begin
      errs++;
      $display("FAIL overrun_3 got %0d want 3", overrun_cnt);
    end
    tx_ready = 1'b1;
    repeat (PKT) step();
    vecs++;
    if (tx_valid !== 1'b0 || overrun_cnt !== 8'd3) begin
      errs++;
      $display("FAIL overrun_drain got v=%b ovr=%0d want 0/3", tx_valid, overrun_cnt);
    end
    tx_ready = 1'b0;
    n = 0;
    while (tx_valid !== 1'b1 && n < 2 * SD) begin step(); n++; end
    repeat (258 * SD) step();
    vecs++;
    if (overrun_cnt !== 8'd255) begin
      errs++;
      $display("FAIL overrun_sat got %0d want 255", overrun_cnt);
    end
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid === 1'b1 && n < 20) begin step(); n++; end
    vecs++;
    if (tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL overrun_sat_drain got tx_valid=%b want 0", tx_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    resp_reads = 1'b0;
    n = 0;
    while (!(spi_start === 1'b1 && spi_frame[56] === 1'b1) && n < SD + 20) begin step(); n++; end
    repeat (TO - 1) step();
    vecs++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL timeout_early got err=%b want 0", err);
    end
    n = 0;
    do begin step(); n++; end while (spi_start !== 1'b1 && n < 10);
    vecs++;
    if (err !== 1'b1 || cfg_done !== 1'b0 || spi_frame !== FMT_F) begin
      errs++;
      $display("FAIL timeout_recover got err=%b cfg=%b frame=%h want 1/0/%h", err, cfg_done, spi_frame, FMT_F);
    end
    resp_reads = 1'b1;
    n = 0;
    while (cfg_done !== 1'b1 && n < 400) begin step(); n++; end
    vecs++;
    if (cfg_done !== 1'b1 || err !== 1'b1) begin
      errs++;
      $display("FAIL timeout_reconfig got cfg=%b err=%b want 1/1", cfg_done, err);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    tx_ready = 1'b1;
    n = 0;
    while (!(tx_valid === 1'b1 && tx_data === 8'h04) && n < 2 * SD + 100) begin step(); n++; end
    tx_ready = 1'b0;
    vecs++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h04) begin
      errs++;
      $display("FAIL mid_pending got v=%b d=%h want 1/04", tx_valid, tx_data);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({spi_start, tx_valid, cfg_done, err} !== 4'b0000 || tx_data !== 8'h00 ||
        spi_frame !== 57'h0 || overrun_cnt !== 8'h00) begin
      errs++;
      $display("FAIL mid_reset got flags=%b d=%h frame=%h ovr=%h want 0000/00/0/00",
               {spi_start, tx_valid, cfg_done, err}, tx_data, spi_frame, overrun_cnt);
    end
    step();
    rst = 1'b0;
    n = 0;
    do begin step(); n++; end while (spi_start !== 1'b1 && n < 200);
    vecs++;
    if (n !== STARTUP + 1 || spi_frame !== FMT_F) begin
      errs++;
      $display("FAIL mid_restart got %0d cycles frame=%h want %0d %h", n, spi_frame, STARTUP + 1, FMT_F);
    end
  endtask

  initial begin
`ifdef ACCEL_SYNC_BYTE_EN
    exp_pkt = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
`else
    exp_pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
`endif
    test_reset();
    test_boot_config();
    test_sample_stream();
    test_backpressure();
    test_overrun();
    test_timeout();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/accel_sample_scheduler.md
# accel_sample_scheduler

Sequencer for the G-sensor SPI link on the DE0-Nano. After reset it configures the accelerometer: data-format write (0x31 = 0x40), then power-control write (0x2D = 0x08). It then issues a multi-byte read burst from 0x32 at a fixed sample rate and streams the six result bytes to the UART transmitter. It sits between the SPI frame engine and the UART TX, and owns all scheduling, timeouts and error recovery.

## Interface
- `CLK_FREQ`, default 5_000_000: system clock in Hz.
- `SAMPLE_RATE`, default 100: read bursts per second; `SAMPLE_DIV = CLK_FREQ/SAMPLE_RATE` (50_000).
- `STARTUP_CYCLES`, default 5_000: settle delay after reset before the first frame.
- `SPI_TIMEOUT`, default 4_096: maximum cycles from `spi_start` to `spi_done`.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `spi_frame` output 57: frame to shift, MSB first: {R/W, MB, addr[5:0], 48 data bits, 1'b1}. Write frames are {W, MB=0, addr, data8, 1'b1, 40'b0}.
- `spi_start` output 1: one-cycle pulse; `spi_frame` is valid in the same cycle.
- `spi_busy` input 1: engine is shifting.
- `spi_done` input 1: one-cycle pulse at the end of the frame.
- `spi_rx_data` input 48: read bytes, `[47:40]` = first byte (addr 0x32); valid with `spi_done`.
- `tx_data` output 8: UART byte.
- `tx_valid` output 1: byte available; held until accepted.
- `tx_ready` input 1: UART idle; a transfer occurs when `tx_valid && tx_ready`.
- `cfg_done` output 1: both config writes have completed.
- `err` output 1: sticky SPI timeout flag; cleared only by `rst`.
- `overrun_cnt` output 8: saturating count of dropped sample ticks.

## Operation
- States:
  - `S_BOOT` counts `STARTUP_CYCLES` → `S_FMT`.
  - `S_FMT` waits for `!spi_busy`, pulses `spi_start` with the FORMAT frame → `S_FMT_W`.
  - `S_FMT_W` on `spi_done` → `S_PWR`.
  - `S_PWR` works the same way with the POWER frame; its `S_PWR_W` on `spi_done` sets `cfg_done` → `S_IDLE`.
  - `S_IDLE` on a sample tick → `S_RD`.
  - `S_RD` waits for `!spi_busy`, pulses `spi_start` with the READ frame {1,1,0x32,48'b0,1'b1} → `S_RD_W`.
  - `S_RD_W` on `spi_done` latches `spi_rx_data` into a 48-bit capture register → `S_TX`.
  - `S_TX` sends the bytes in the order `[47:40]`, `[39:32]`, …, `[7:0]`. After the last handshake → `S_IDLE`.
- Sample tick:
  - Free-running counter `0..SAMPLE_DIV-1`, enabled only while `cfg_done=1`.
  - The tick is a one-cycle pulse on wrap.
  - The counter does not pause during `S_RD`/`S_TX`.
- Overrun: a tick that arrives in any state other than `S_IDLE` is dropped and increments `overrun_cnt`, saturating at 255. If a tick and the return to `S_IDLE` occur in the same cycle, the tick counts as an overrun and is not served.
- Timeout:
  - A watchdog counter runs in each `*_W` state.
  - On reaching `SPI_TIMEOUT` without `spi_done`: set `err`, clear `cfg_done`, clear the sample counter, → `S_FMT`.
  - `spi_done` arriving in the same cycle as the timeout wins; no error is raised.
- Stray pulse: `spi_done` outside a `*_W` state is ignored.
- `tx_data` is stable while `tx_valid=1`. `tx_valid` never deasserts without a handshake, except on `rst`.
- Reset mid-operation: any in-progress SPI or UART activity is abandoned; the block returns to `S_BOOT` and repeats full configuration.

## Timing
- Reset values: `spi_start=0`, `spi_frame=0`, `tx_valid=0`, `tx_data=0`, `cfg_done=0`, `err=0`, `overrun_cnt=0`.
- All outputs are registered.
- `spi_start` rises at least 1 cycle after `!spi_busy` is sampled in an issuing state.
- After `spi_done` of a read, `tx_valid` rises exactly 1 cycle later, presenting byte 0.
- Each subsequent byte appears the cycle after its predecessor's handshake, so back-to-back acceptance gives 1 byte/cycle.
- First `spi_start` occurs `STARTUP_CYCLES+1` cycles after `rst` deasserts.
- `cfg_done` rises the cycle after the POWER frame's `spi_done`.
- The first sample tick comes `SAMPLE_DIV` cycles after `cfg_done` rises.

## Configuration
- `ACCEL_SYNC_BYTE_EN`
  - Defined: each UART packet is 8 bytes, 0xA5 sync byte, then the 6 data bytes, then an XOR checksum of the 6 data bytes. `tx_valid` presents 0xA5 1 cycle after `spi_done`.
  - Undefined: the packet is exactly the 6 raw data bytes.

## Test plan
- **Boot and config:** release `rst`, engine answers `spi_done` 60 cycles after each start → FORMAT frame {0,0,0x31,0x40,1,40'b0} then POWER frame {0,0,0x2D,0x08,1,40'b0}; `cfg_done`=1; no read frame before the first tick.
- **Sample stream:** `spi_rx_data`=0x0102_0304_0506, `tx_ready`=1 → bytes 01,02,03,04,05,06 on consecutive handshakes (with macro: A5,01..06,07).
- **Backpressure:** hold `tx_ready`=0 for 100 cycles during byte 2 → `tx_data`=0x03 and `tx_valid`=1 stable throughout; the stream then resumes in order.
- **Overrun:** hold `tx_ready`=0 for 3×`SAMPLE_DIV` → `overrun_cnt`=3; with `tx_ready` stuck low for longer, the count saturates at 255.
- **Timeout:** engine never asserts `spi_done` on a read → `err`=1 after 4_096 cycles, `cfg_done`=0, next frame is FORMAT; `err` stays 1 after successful reconfiguration.
- **Reset mid-burst:** assert `rst` while byte 3 is pending → all outputs return to reset values immediately; the sequence restarts with `S_BOOT`.
